// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Small prefetch FIFO of {pc, instr} entries; the head is read straight from storage.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  storage [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = storage[rd_ptr_reg];

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues one fetch per cycle into the prefetch buffer and hands {pc, instr} to decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
    localparam int          CW      = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state_reg;
    fetch_state_t  state_next;
    logic [31:0]   pc_reg;
    logic [31:0]   pc_next;
    logic          pop;
    logic          push;
    logic          push_ok;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    assign imem_addr = pc_reg;
    assign halted    = (state_reg == HALT);

    assign out_valid = (buf_count != '0);
    assign out_pc    = buf_empty ? 32'h0 : head.pc;
    assign out_instr = buf_empty ? 32'h0 : head.instr;

    assign pop       = out_valid && out_ready;
    assign push_ok   = !buf_full || pop;
    // A redirect discards whatever would have been pushed or popped this cycle.
    assign push      = (state_reg == FETCH) && push_ok && !redirect_valid;
    assign push_data = '{pc: pc_reg, instr: imem_instr};

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop && !redirect_valid),
        .flush     (redirect_valid),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= PC_INIT;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_valid) begin
            pc_next    = {redirect_pc[31:2], 2'b00};
            state_next = fetch_en ? FETCH : IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fetch_en) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (push) begin
                        pc_next = pc_reg + WORD_BYTES;
                    end
                    // The halt word is still pushed so decode sees it; sequencing stops after it.
                    if (push && (imem_instr == HALT_WORD)) begin
                        state_next = HALT;
                    end else if (!fetch_en) begin
                        state_next = IDLE;
                    end
                end
                HALT: begin
                    if (!fetch_en) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: streaming, back-pressure, redirects, halt, PC wrap and async reset.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    // Second instance exercising PC wrap-around from the top of the address space.
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_instr;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic        w_halted;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_out_ready;

    logic [31:0] mem [16];
    logic [31:0] exp_pc [4];
    logic [31:0] exp_instr [4];

    int checks;
    int errors;

    assign imem_instr   = mem[imem_addr[5:2]];
    assign w_imem_instr = mem[w_imem_addr[5:2]];

    fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2),
        .HALT_WORD (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    fetch_sequencer #(
        .RESET_PC  (32'hFFFF_FFFC),
        .BUF_DEPTH (2),
        .HALT_WORD (32'h0000_0000)
    ) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (w_imem_addr),
        .imem_instr     (w_imem_instr),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .out_valid      (w_out_valid),
        .out_ready      (w_out_ready),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .halted         (w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step(2);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", out_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", imem_addr); end
        checks++; if (w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_wrap_addr got %h want fffffffc", w_imem_addr); end
        $display("reset: addr=%h valid=%b halted=%b", imem_addr, out_valid, halted);
    endtask

    task automatic test_stream_halt();
        apply_reset();
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            $display("stream: valid=%b pc=%h instr=%h", out_valid, out_pc, out_instr);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", k, out_valid); end
            checks++; if (out_pc !== exp_pc[k]) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", k, out_pc, exp_pc[k]); end
            checks++; if (out_instr !== exp_instr[k]) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", k, out_instr, exp_instr[k]); end
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
        step(3);
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL halt_addr got %h want 00000010", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_drained got %b want 0", out_valid); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold got %b want 1", halted); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        step(5);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr got %h want 00000008", imem_addr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL bp_pc got %h want 00000000", out_pc); end
        step(2);
        checks++; if (out_instr !== 32'hAABB_CCDD) begin errors++; $display("FAIL bp_hold_instr got %h want aabbccdd", out_instr); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_hold_addr got %h want 00000008", imem_addr); end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step(1);
            $display("resume: valid=%b pc=%h instr=%h", out_valid, out_pc, out_instr);
            checks++; if (out_pc !== exp_pc[k]) begin errors++; $display("FAIL bp_resume_pc[%0d] got %h want %h", k, out_pc, exp_pc[k]); end
            checks++; if (out_instr !== exp_instr[k]) begin errors++; $display("FAIL bp_resume_instr[%0d] got %h want %h", k, out_instr, exp_instr[k]); end
        end
    endtask

    task automatic test_redirect_full();
        apply_reset();
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        step(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", out_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL redir_addr got %h want 00000004", imem_addr); end
        step(1);
        $display("redirect: valid=%b pc=%h instr=%h", out_valid, out_pc, out_instr);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_first_valid got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL redir_first_pc got %h want 00000004", out_pc); end
        checks++; if (out_instr !== 32'h1234_5678) begin errors++; $display("FAIL redir_first_instr got %h want 12345678", out_instr); end
    endtask

    task automatic test_halt_redirect();
        apply_reset();
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step(7);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hr_halted got %b want 1", halted); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hr_unhalt got %b want 0", halted); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL hr_addr got %h want 00000000", imem_addr); end
        for (int k = 0; k < 2; k++) begin
            step(1);
            $display("replay: valid=%b pc=%h instr=%h", out_valid, out_pc, out_instr);
            checks++; if (out_pc !== exp_pc[k]) begin errors++; $display("FAIL hr_replay_pc[%0d] got %h want %h", k, out_pc, exp_pc[k]); end
            checks++; if (out_instr !== exp_instr[k]) begin errors++; $display("FAIL hr_replay_instr[%0d] got %h want %h", k, out_instr, exp_instr[k]); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        step(2);
        $display("wrap: valid=%b pc=%h instr=%h", w_out_valid, w_out_pc, w_out_instr);
        checks++; if (w_out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", w_out_valid); end
        checks++; if (w_out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h want fffffffc", w_out_pc); end
        step(1);
        $display("wrap: valid=%b pc=%h instr=%h", w_out_valid, w_out_pc, w_out_instr);
        checks++; if (w_out_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h want 00000000", w_out_pc); end
        checks++; if (w_out_instr !== 32'hAABB_CCDD) begin errors++; $display("FAIL wrap_instr1 got %h want aabbccdd", w_out_instr); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step(3);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr got %h want 00000000", imem_addr); end
        step(1);
        rst_n = 1'b1;
        step(2);
        $display("restart: valid=%b pc=%h instr=%h", out_valid, out_pc, out_instr);
        checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL ar_restart got valid=%b pc=%h want valid=1 pc=00000000", out_valid, out_pc); end
        checks++; if (out_instr !== 32'hAABB_CCDD) begin errors++; $display("FAIL ar_restart_instr got %h want aabbccdd", out_instr); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;
        w_out_ready      = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[0] = 32'hAABB_CCDD;
        mem[1] = 32'h1234_5678;
        mem[2] = 32'h8765_4321;
        mem[3] = 32'h0000_0000;
        exp_pc[0] = 32'h0; exp_instr[0] = 32'hAABB_CCDD;
        exp_pc[1] = 32'h4; exp_instr[1] = 32'h1234_5678;
        exp_pc[2] = 32'h8; exp_instr[2] = 32'h8765_4321;
        exp_pc[3] = 32'hC; exp_instr[3] = 32'h0000_0000;

        test_reset();
        test_stream_halt();
        test_backpressure();
        test_redirect_full();
        test_halt_redirect();
        test_wrap();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
